ucsbece154a_memarb: RTL and testbench

Two-requester arbiter and sequencer for the single-ported unified instruction/data memory of the multicycle core. It shares the memory between the core's memory port (fetch, lw, sw) and the debug/program-loader port. It grants one access at a time with round-robin fairness, holds address and data stable for a fixed memory latency, and returns read data with a one-cycle done pulse. It sits between the core datapath's Adr/WriteData/MemWrite signals and the memory macro.

---
 rtl/ucsbece154a_memarb.sv | 114 +++++++++++
 tb/tb_ucsbece154a_memarb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_memarb.sv
// Round-robin arbiter/sequencer sharing one single-ported memory between the
// core and debug ports; one access in flight, fixed LAT-cycle access window.
module ucsbece154a_memarb #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req_i,
  input  logic        c_we_i,
  input  logic [31:0] c_adr_i,
  input  logic [31:0] c_wd_i,
  output logic [31:0] c_rd_o,
  output logic        c_done_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_wd_i,
  output logic [31:0] d_rd_o,
  output logic        d_done_o,
  output logic        mem_we_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
  } req_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  req_t             txn_q, txn_d;
  logic             mem_we_q, mem_we_d;
  logic [1:0][31:0] rd_q, rd_d;
  logic [1:0]       done_q, done_d;

  logic [1:0] req;
  req_t [1:0] port;
  logic       gnt;

  assign req     = {d_req_i, c_req_i};
  assign port[0] = {c_we_i, c_adr_i, c_wd_i};
  assign port[1] = {d_we_i, d_adr_i, d_wd_i};

  // On a tie the port that lost last time wins; last_q also names the
  // port owning the transaction in flight.
  assign gnt = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    txn_d    = txn_q;
    mem_we_d = 1'b0;
    rd_d     = rd_q;
    done_d   = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          txn_d    = port[gnt];
          last_d   = gnt;
          cnt_d    = CNT_LOAD;
          mem_we_d = port[gnt].we;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          if (!txn_q.we) rd_d[last_q] = mem_rd_i;
          done_d[last_q] = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      txn_q    <= '0;
      mem_we_q <= 1'b0;
      rd_q     <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      txn_q    <= txn_d;
      mem_we_q <= mem_we_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
    end
  end

  assign mem_we_o  = mem_we_q;
  assign mem_adr_o = txn_q.adr;
  assign mem_wd_o  = txn_q.wd;
  assign c_rd_o    = rd_q[0];
  assign d_rd_o    = rd_q[1];
  assign c_done_o  = done_q[0];
  assign d_done_o  = done_q[1];

endmodule

// File: tb/tb_ucsbece154a_memarb.sv
// Bench for ucsbece154a_memarb: three instances (LAT 2, 1, 3), each with its own
// memory; directed vectors, hand sequences and a randomized run against a timing model.
module tb_ucsbece154a_memarb;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
  } pin_t;

  typedef struct {
    int          li;
    bit          port;
    bit          we;
    bit          drop;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] c_rd;
    logic [31:0] d_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pin_t        pin     [3][2];
  logic [31:0] rd      [3][2];
  logic        done    [3][2];
  logic        mem_we  [3];
  logic [31:0] mem_adr [3];
  logic [31:0] mem_wd  [3];
  logic [31:0] mem_rd  [3];
  logic [31:0] mem     [3][256];
  bit [255:0]  written [3];

  int    n_tests = 0;
  int    n_fail  = 0;
  string ctx     = "";

  function automatic logic [31:0] init_word(input logic [7:0] k);
    return (k == 8'd4) ? 32'hDEADBEEF : {24'hC0DE00, k};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ucsbece154a_memarb #(.LAT((g == 0) ? 2 : (g == 1) ? 1 : 3)) u_dut (
      .clk(clk), .reset(reset),
      .c_req_i(pin[g][0].req), .c_we_i(pin[g][0].we), .c_adr_i(pin[g][0].adr),
      .c_wd_i(pin[g][0].wd), .c_rd_o(rd[g][0]), .c_done_o(done[g][0]),
      .d_req_i(pin[g][1].req), .d_we_i(pin[g][1].we), .d_adr_i(pin[g][1].adr),
      .d_wd_i(pin[g][1].wd), .d_rd_o(rd[g][1]), .d_done_o(done[g][1]),
      .mem_we_o(mem_we[g]), .mem_adr_o(mem_adr[g]), .mem_wd_o(mem_wd[g]),
      .mem_rd_i(mem_rd[g])
    );
  end

  // Memory macro: unwritten words read back a fixed address pattern
  always_comb begin
    for (int g = 0; g < 3; g++)
      mem_rd[g] = written[g][mem_adr[g][9:2]] ? mem[g][mem_adr[g][9:2]]
                                              : init_word(mem_adr[g][9:2]);
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++)
      if (mem_we[g]) begin
        mem[g][mem_adr[g][9:2]]     <= mem_wd[g];
        written[g][mem_adr[g][9:2]] <= 1'b1;
      end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h, expected %h", ctx, name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 2; p++) pin[i][p] = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic chk_reset(input int i);
    chk("mem_we", mem_we[i], 0);
    chk("mem_adr", mem_adr[i], 0);
    chk("mem_wd", mem_wd[i], 0);
    chk("c_rd", rd[i][0], 0);
    chk("d_rd", rd[i][1], 0);
    chk("c_done", done[i][0], 0);
    chk("d_done", done[i][1], 0);
  endtask

  // Single transaction from IDLE; mutates the port after the grant
  task automatic run_vec(input vec_t v);
    int i, lat;
    i   = v.li;
    lat = lat_of(i);
    pin[i][v.port] = {1'b1, v.we, v.adr, v.wd};
    for (int t = 1; t <= lat + 1; t++) begin
      @(posedge clk); #1;
      chk("mem_we", mem_we[i], (t == 1) ? v.we : 1'b0);
      if (t <= lat) begin
        chk("mem_adr", mem_adr[i], v.adr);
        if (v.we) chk("mem_wd", mem_wd[i], v.wd);
      end
      chk("own done", done[i][v.port], (t == lat + 1));
      chk("other done", done[i][!v.port], 0);
      if (t == 1) begin
        pin[i][v.port].adr = ~v.adr;
        pin[i][v.port].wd  = ~v.wd;
        pin[i][v.port].we  = ~v.we;
        if (v.drop) pin[i][v.port].req = 1'b0;
      end
      if (t == lat + 1) begin
        chk("c_rd", rd[i][0], v.c_rd);
        chk("d_rd", rd[i][1], v.d_rd);
        pin[i][v.port] = '0;
      end
    end
    @(posedge clk); #1;
    chk("idle c_done", done[i][0], 0);
    chk("idle d_done", done[i][1], 0);
  endtask

  // Steps n cycles with reads pending; each port drops req only in the cycle after its done
  task automatic watch(input int i, input int n, input int c0, input int c1,
                       input int d0, input int d1, input logic [31:0] crd,
                       input logic [31:0] drd);
    for (int t = 1; t <= n; t++) begin
      @(posedge clk); #1;
      chk("c_done", done[i][0], (t == c0 || t == c1));
      chk("d_done", done[i][1], (t == d0 || t == d1));
      chk("mem_we", mem_we[i], 0);
      if (t == c0 || t == c1) chk("c_rd", rd[i][0], crd);
      if (t == d0 || t == d1) chk("d_rd", rd[i][1], drd);
      pin[i][0].req = !(t == c0 || t == c1);
      pin[i][1].req = !(t == d0 || t == d1);
    end
    pin[i][0] = '0;
    pin[i][1] = '0;
  endtask

  // Model: the memory is free again LAT+2 cycles after a grant; ties go to the
  // port not granted last; results are due LAT+1 cycles after the grant.
  task automatic run_random(input int i, input int ncyc);
    int          lat, free_at, we_at, g;
    int          done_at [2];
    bit          pend_we [2], busy [2], granted [2], cool [2];
    logic [31:0] pend_rd [2], exp_rd [2];
    logic [31:0] exp_adr, exp_wd;
    logic [31:0] mm [256];
    bit          mw [256];
    bit          last;
    logic [7:0]  k;
    lat = lat_of(i); free_at = 0; we_at = -1; last = 1'b1;
    exp_adr = '0; exp_wd = '0;
    for (int p = 0; p < 2; p++) begin
      done_at[p] = -1; exp_rd[p] = '0; pend_rd[p] = '0; pend_we[p] = 0;
      busy[p] = 0; granted[p] = 0; cool[p] = 0;
    end
    for (int a = 0; a < 256; a++) mw[a] = 0;
    for (int now = 0; now < ncyc; now++) begin
      for (int p = 0; p < 2; p++) begin
        if (cool[p]) begin
          pin[i][p].req = 1'b0;
          cool[p] = 0;
        end else if (!busy[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            busy[p] = 1;
            pin[i][p] = {1'b1, 1'($urandom_range(0, 1)),
                         32'h200 | (32'($urandom_range(0, 63)) << 2), 32'($urandom)};
          end
        end else if (granted[p]) begin
          if ($urandom_range(0, 3) == 0) pin[i][p].req = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            pin[i][p].we  = 1'($urandom_range(0, 1));
            pin[i][p].adr = 32'($urandom);
            pin[i][p].wd  = 32'($urandom);
          end
        end
      end
      if (now >= free_at && (pin[i][0].req || pin[i][1].req)) begin
        g = (pin[i][0].req && pin[i][1].req) ? int'(!last) : int'(pin[i][1].req);
        last = g[0];
        k = pin[i][g].adr[9:2];
        exp_adr = pin[i][g].adr;
        exp_wd  = pin[i][g].wd;
        pend_we[g] = pin[i][g].we;
        if (pin[i][g].we) begin
          mm[k] = pin[i][g].wd; mw[k] = 1; we_at = now + 1;
        end else begin
          pend_rd[g] = mw[k] ? mm[k] : init_word(k);
        end
        done_at[g] = now + lat + 1;
        free_at    = now + lat + 2;
        granted[g] = 1;
      end
      @(posedge clk); #1;
      ctx = $sformatf("rnd lat%0d cyc%0d", lat, now + 1);
      for (int p = 0; p < 2; p++) begin
        chk(p ? "d_done" : "c_done", done[i][p], (now + 1 == done_at[p]));
        if (now + 1 == done_at[p]) begin
          if (!pend_we[p]) exp_rd[p] = pend_rd[p];
          busy[p] = 0; granted[p] = 0; cool[p] = 1;
        end
        chk(p ? "d_rd" : "c_rd", rd[i][p], exp_rd[p]);
      end
      chk("mem_we", mem_we[i], (now + 1 == we_at));
      chk("mem_adr", mem_adr[i], exp_adr);
      chk("mem_wd", mem_wd[i], exp_wd);
    end
    pin[i][0] = '0;
    pin[i][1] = '0;
  endtask

  initial begin
    vec_t vecs [11];
    vecs[0]  = '{0, 0, 0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 1, 1, 0, 32'h40, 32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{0, 0, 0, 1, 32'h40, 32'h0,        32'h12345678, 32'h0};
    vecs[3]  = '{0, 1, 0, 0, 32'h10, 32'h0,        32'h12345678, 32'hDEADBEEF};
    vecs[4]  = '{1, 0, 0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1, 0, 0, 0, 32'h14, 32'h0,        32'hC0DE0005, 32'h0};
    vecs[6]  = '{1, 1, 1, 0, 32'h80, 32'h0BADC0DE, 32'hC0DE0005, 32'h0};
    vecs[7]  = '{1, 1, 0, 1, 32'h80, 32'h0,        32'hC0DE0005, 32'h0BADC0DE};
    vecs[8]  = '{2, 0, 1, 0, 32'h20, 32'hCAFEF00D, 32'h0,        32'h0};
    vecs[9]  = '{2, 1, 0, 0, 32'h20, 32'h0,        32'h0,        32'hCAFEF00D};
    vecs[10] = '{2, 0, 0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};

    do_reset();
    for (int i = 0; i < 3; i++) begin
      ctx = $sformatf("reset inst%0d", i);
      chk_reset(i);
    end

    for (int n = 0; n < 11; n++) begin
      ctx = $sformatf("vec%0d", n);
      run_vec(vecs[n]);
    end

    // Both ports contend from reset: core, debug, core, debug every LAT+2 cycles
    do_reset();
    ctx = "tie lat2";
    pin[0][0] = {1'b1, 1'b0, 32'h10, 32'h0};
    pin[0][1] = {1'b1, 1'b0, 32'h14, 32'h0};
    watch(0, 15, 3, 11, 7, 15, 32'hDEADBEEF, 32'hC0DE0005);

    // Reset during the first BUSY cycle of a core write, LAT=3
    do_reset();
    ctx = "rst-busy";
    pin[2][0] = {1'b1, 1'b1, 32'h60, 32'h55AA55AA};
    @(posedge clk); #1;
    chk("strobe", mem_we[2], 1);
    chk("strobe adr", mem_adr[2], 32'h60);
    reset = 1'b1;
    pin[2][0] = '0;
    @(posedge clk); #1;
    chk_reset(2);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no strobe", mem_we[2], 0);
      chk("no done", done[2][0], 0);
    end
    ctx = "rst-tie";
    pin[2][0] = {1'b1, 1'b0, 32'h10, 32'h0};
    pin[2][1] = {1'b1, 1'b0, 32'h14, 32'h0};
    watch(2, 9, 4, -1, 9, -1, 32'hDEADBEEF, 32'hC0DE0005);

    // LAT=1 core holding req: a new read every 3 cycles
    do_reset();
    ctx = "b2b lat1";
    pin[1][0] = {1'b1, 1'b0, 32'h100, 32'h0};
    for (int t = 1; t <= 11; t++) begin
      @(posedge clk); #1;
      chk("c_done", done[1][0], (t % 3 == 2));
      chk("d_done", done[1][1], 0);
      chk("mem_we", mem_we[1], 0);
      if (t % 3 == 2) begin
        chk("c_rd", rd[1][0], init_word(8'(64 + (t - 2) / 3)));
        pin[1][0].adr = 32'h100 + 32'(4 * ((t + 1) / 3));
      end
      if (t == 11) pin[1][0] = '0;
    end

    for (int i = 0; i < 3; i++) begin
      do_reset();
      run_random(i, 300);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
